// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized input, mid-bit sampling at a rate
// latched per frame, one-cycle dataValid / frameError strobes.
module uart_rx #(
    parameter int unsigned CPB_1200 = 41667,
    parameter int unsigned CPB_2400 = 20833,
    parameter int unsigned CPB_4800 = 10417,
    parameter int unsigned CPB_9600 = 5208
) (
    input  logic       clkRx,
    input  logic       reset,
    input  logic       serialIn,
    input  logic [1:0] baudRate,
    output logic [7:0] dataOut,
    output logic       dataValid,
    output logic       frameError,
    output logic       busy
);

    localparam int unsigned MAX_A   = (CPB_1200 > CPB_2400) ? CPB_1200 : CPB_2400;
    localparam int unsigned MAX_B   = (CPB_4800 > CPB_9600) ? CPB_4800 : CPB_9600;
    localparam int unsigned CPB_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(CPB_MAX + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic             rx_meta_q, rx_sync_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cpb_q, cpb_d;
    logic [CNT_W-1:0] cpb_sel, cpb_m1, half_m1;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    always_ff @(posedge clkRx or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= serialIn;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_comb begin
        case (baudRate)
            2'b00:   cpb_sel = CNT_W'(CPB_1200);
            2'b01:   cpb_sel = CNT_W'(CPB_2400);
            2'b10:   cpb_sel = CNT_W'(CPB_4800);
            default: cpb_sel = CNT_W'(CPB_9600);
        endcase
    end

    assign cpb_m1  = cpb_q - CNT_W'(1);
    assign half_m1 = (cpb_q >> 1) - CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cpb_d   = cpb_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_sync_q) begin
                    cpb_d   = cpb_sel;
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == half_m1) begin
                    if (!rx_sync_q) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == cpb_m1) begin
                    shift_d[idx_q] = rx_sync_q;
                    cnt_d          = '0;
                    if (idx_q == 3'd7) state_d = S_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == cpb_m1) begin
                    if (rx_sync_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // A held-low line (break) parks here so it yields a single error.
            S_WAIT_HIGH: begin
                if (rx_sync_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clkRx or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cpb_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cpb_q   <= cpb_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign dataOut    = data_q;
    assign dataValid  = valid_q;
    assign frameError = ferr_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected strobes, a negedge
// monitor pops and compares them as the receiver produces them.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ser = 1'b1;
    logic [1:0] baud = 2'b11;
    logic [7:0] dout;
    logic       dval, ferr, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ferr_seen = 0;

    typedef struct {
        bit         is_ferr;
        logic [7:0] data;
        int         at_cyc;
    } exp_t;
    exp_t sb[$];

    uart_rx #(
        .CPB_1200(24),
        .CPB_2400(20),
        .CPB_4800(18),
        .CPB_9600(16)
    ) dut (
        .clkRx(clk),
        .reset(rst_n),
        .serialIn(ser),
        .baudRate(baud),
        .dataOut(dout),
        .dataValid(dval),
        .frameError(ferr),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, time %0t", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expected event per strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dval && ferr) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL strobe_overlap: dataValid and frameError both 1 at cycle %0d", cyc);
            end
            if (ferr) ferr_seen = ferr_seen + 1;
            if (dval || ferr) begin
                checks = checks + 1;
                if (sb.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected_strobe: valid=%0b ferr=%0b data=%0h cycle %0d, none expected",
                             dval, ferr, dout, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (ferr !== e.is_ferr || (!e.is_ferr && dout !== e.data) ||
                        (e.at_cyc >= 0 && cyc != e.at_cyc)) begin
                        errors = errors + 1;
                        $display("FAIL strobe: got ferr=%0b data=%0h cycle %0d, expected ferr=%0b data=%0h cycle %0d",
                                 ferr, dout, cyc, e.is_ferr, e.data, e.at_cyc);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame; the expected strobe lands 3 + cpb/2 + 9*cpb edges after the start-bit drive.
    task automatic send_frame(input logic [7:0] b, input int cpb, input bit stop_ok,
                              input bit timed, input bit sw, input logic [1:0] sw_rate);
        exp_t e;
        e.is_ferr = !stop_ok;
        e.data    = b;
        e.at_cyc  = timed ? (cyc + 3 + cpb / 2 + 9 * cpb) : -1;
        sb.push_back(e);
        ser = 1'b0;
        tick(cpb);
        if (sw) baud = sw_rate;
        for (int i = 0; i < 8; i++) begin
            ser = b[i];
            tick(cpb);
        end
        ser = stop_ok;
        tick(cpb);
    endtask

    initial begin
        logic [7:0] prior;
        int f0, bcnt;

        #1;
        check("reset_dataOut", dout, 8'h00);
        check("reset_valid", dval, 1'b0);
        check("reset_ferr", ferr, 1'b0);
        check("reset_busy", busy, 1'b0);
        tick(3);
        rst_n = 1'b1;
        tick(5);

        // Ideal 0xA5 at cpb 16 with exact strobe timing.
        baud = 2'b11;
        send_frame(8'hA5, 16, 1'b1, 1'b1, 1'b0, 2'b00);
        tick(4);
        check("a5_dataOut", dout, 8'hA5);
        check("a5_busy_low", busy, 1'b0);

        // Back-to-back frames, no idle gap.
        send_frame(8'h00, 16, 1'b1, 1'b1, 1'b0, 2'b00);
        send_frame(8'hFF, 16, 1'b1, 1'b1, 1'b0, 2'b00);
        tick(4);
        check("b2b_dataOut", dout, 8'hFF);

        // 3-cycle glitch: busy high for exactly cpb/2 = 8 cycles.
        ser = 1'b0;
        tick(3);
        ser = 1'b1;
        bcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
        tick(1);
        check("glitch_busy_cycles", bcnt, 8);
        check("glitch_dataOut", dout, 8'hFF);

        // Stop bit low then break: single frameError, dataOut held.
        prior = dout;
        f0 = ferr_seen;
        send_frame(8'h3C, 16, 1'b0, 1'b1, 1'b0, 2'b00);
        tick(100);
        check("break_ferr_count", ferr_seen - f0, 1);
        check("break_dataOut_held", dout, prior);
        check("break_busy_wait_high", busy, 1'b1);
        ser = 1'b1;
        tick(4);
        check("break_exit_busy", busy, 1'b0);
        tick(4);

        // Reset during data bit 4.
        ser = 1'b0;
        tick(16);
        for (int i = 0; i < 4; i++) begin
            ser = i[0];
            tick(16);
        end
        ser = 1'b1;
        tick(4);
        check("pre_reset_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_dataOut", dout, 8'h00);
        check("midreset_valid", dval, 1'b0);
        check("midreset_ferr", ferr, 1'b0);
        check("midreset_busy", busy, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        send_frame(8'h5A, 16, 1'b1, 1'b1, 1'b0, 2'b00);
        tick(4);
        check("post_reset_dataOut", dout, 8'h5A);

        // All bytes, rate switched after the start bit; receiver must keep the latched rate.
        for (int v = 0; v < 256; v++) begin
            if (v[0] == 1'b0) begin
                baud = 2'b11;
                send_frame(8'(v), 16, 1'b1, 1'b1, 1'b1, 2'b00);
            end else begin
                baud = 2'b00;
                send_frame(8'(v), 24, 1'b1, 1'b1, 1'b1, 2'b11);
            end
        end
        tick(10);
        check("final_dataOut", dout, 8'hFF);
        check("scoreboard_drained", sb.size(), 0);
        check("final_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
